// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - next-PC unit with return-address stack and HALT/resume state
module pc_sequencer #(
    parameter int              AW        = 32,
    parameter int              RAS_DEPTH = 8,
    parameter int              STEP      = 1,
    parameter logic [AW-1:0]   RESET_PC  = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          adv,
    input  logic [2:0]    op,
    input  logic [1:0]    br_type,
    input  logic [2:0]    flags,
    input  logic [15:0]   imm16,
    input  logic [25:0]   imm26,
    input  logic          resume,
    output logic [AW-1:0] pc,
    output logic [AW-1:0] pc_next,
    output logic          halted,
    output logic          ras_empty,
    output logic          ras_full,
    output logic          ras_err
);

    localparam int        PW       = $clog2(RAS_DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(RAS_DEPTH);

    localparam logic [2:0] OP_BR   = 3'b001;
    localparam logic [2:0] OP_JMP  = 3'b010;
    localparam logic [2:0] OP_CALL = 3'b011;
    localparam logic [2:0] OP_RET  = 3'b100;
    localparam logic [2:0] OP_HALT = 3'b101;

    typedef enum logic {S_RUN, S_HALT} state_t;

    state_t          state_q;
    logic [AW-1:0]   pc_q;
    logic [AW-1:0]   ras_q [RAS_DEPTH];
    logic [PW-1:0]   ptr_q;
    logic [PW:0]     cnt_q;
    logic            err_q;

    logic [AW-1:0]   seq_d;
    logic [AW-1:0]   br_tgt_d;
    logic [AW-1:0]   j_tgt_d;
    logic [PW-1:0]   top_idx;
    logic            br_take;
    logic            ras_is_empty;
    logic            ras_is_full;
    logic            unused_carry;

    assign unused_carry = flags[2];
    assign seq_d        = pc_q + AW'(STEP);
    assign br_tgt_d     = seq_d + {{(AW-16){imm16[15]}}, imm16};
    assign j_tgt_d      = seq_d + {{(AW-26){imm26[25]}}, imm26};
    assign top_idx      = ptr_q - PW'(1);
    assign ras_is_empty = (cnt_q == '0);
    assign ras_is_full  = (cnt_q == FULL_CNT);

    always_comb begin
        br_take = 1'b0;
        case (br_type)
            2'b00: br_take = flags[0];
            2'b01: br_take = ~flags[0];
            2'b10: br_take = ~flags[1];
            2'b11: br_take = flags[1];
            default: br_take = 1'b0;
        endcase
    end

    always_comb begin
        pc_next = seq_d;
        case (op)
            OP_BR:           pc_next = br_take ? br_tgt_d : seq_d;
            OP_JMP, OP_CALL: pc_next = j_tgt_d;
            OP_RET:          pc_next = ras_is_empty ? seq_d : ras_q[top_idx];
            OP_HALT:         pc_next = pc_q;
            default:         pc_next = seq_d;
        endcase
    end

    // The write pointer wraps, so a push while full lands on the oldest entry.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_RUN;
            pc_q    <= RESET_PC;
            ptr_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (adv) begin
                        pc_q <= pc_next;
                        case (op)
                            OP_CALL: begin
                                ras_q[ptr_q] <= seq_d;
                                ptr_q        <= ptr_q + PW'(1);
                                if (ras_is_full) err_q <= 1'b1;
                                else             cnt_q <= cnt_q + (PW+1)'(1);
                            end
                            OP_RET: begin
                                if (ras_is_empty) begin
                                    err_q <= 1'b1;
                                end else begin
                                    ptr_q <= top_idx;
                                    cnt_q <= cnt_q - (PW+1)'(1);
                                end
                            end
                            OP_HALT: state_q <= S_HALT;
                            default: ;
                        endcase
                    end
                end
                S_HALT: begin
                    if (resume) state_q <= S_RUN;
                end
                default: state_q <= S_RUN;
            endcase
        end
    end

    assign pc        = pc_q;
    assign halted    = (state_q == S_HALT);
    assign ras_empty = ras_is_empty;
    assign ras_full  = ras_is_full;
    assign ras_err   = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer
module tb_pc_sequencer;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        adv = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [1:0]  br_type = 2'b00;
    logic [2:0]  flags = 3'b000;
    logic [15:0] imm16 = '0;
    logic [25:0] imm26 = '0;
    logic        resume = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        halted, ras_empty, ras_full, ras_err;

    pc_sequencer dut (
        .clk(clk), .reset(reset), .adv(adv), .op(op), .br_type(br_type),
        .flags(flags), .imm16(imm16), .imm26(imm26), .resume(resume),
        .pc(pc), .pc_next(pc_next), .halted(halted), .ras_empty(ras_empty),
        .ras_full(ras_full), .ras_err(ras_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        h;
        logic        e;
        logic        f;
        logic        r;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_ras[$];
    logic [31:0] m_pc;
    logic        m_halt;
    logic        m_err;
    int          n_checks = 0;
    int          n_errs = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_out();
        exp_t e;
        e = sb.pop_front();
        chk({e.tag, ".pc"}, pc, e.pc);
        chk({e.tag, ".halted"}, {31'b0, halted}, {31'b0, e.h});
        chk({e.tag, ".empty"}, {31'b0, ras_empty}, {31'b0, e.e});
        chk({e.tag, ".full"}, {31'b0, ras_full}, {31'b0, e.f});
        chk({e.tag, ".err"}, {31'b0, ras_err}, {31'b0, e.r});
    endtask

    task automatic push_exp(input string tag);
        exp_t e;
        e.tag = tag;
        e.pc  = m_pc;
        e.h   = m_halt;
        e.e   = (m_ras.size() == 0);
        e.f   = (m_ras.size() == DEPTH);
        e.r   = m_err;
        sb.push_back(e);
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b0; adv = 1'b1; op = 3'b010; imm26 = 26'd5; resume = 1'b0;
        for (int i = 0; i < cycles; i++) @(posedge clk);
        m_pc = 32'd0; m_halt = 1'b0; m_err = 1'b0; m_ras.delete();
        push_exp("reset");
        #1;
        compare_out();
        reset = 1'b1; adv = 1'b0;
    endtask

    task automatic step(input string tag, input logic a, input logic [2:0] o,
                        input logic [1:0] bt, input logic [2:0] fl,
                        input logic [15:0] i16, input logic [25:0] i26,
                        input logic rs, input logic check_next);
        logic [31:0] seq, brt, jt, nxt;
        logic        cond;
        adv = a; op = o; br_type = bt; flags = fl; imm16 = i16; imm26 = i26; resume = rs;
        seq  = m_pc + 32'd1;
        brt  = seq + {{16{i16[15]}}, i16};
        jt   = seq + {{6{i26[25]}}, i26};
        cond = (bt == 2'b00) ? fl[0] : (bt == 2'b01) ? !fl[0] : (bt == 2'b10) ? !fl[1] : fl[1];
        case (o)
            3'b001: nxt = cond ? brt : seq;
            3'b010, 3'b011: nxt = jt;
            3'b100: nxt = (m_ras.size() > 0) ? m_ras[m_ras.size()-1] : seq;
            3'b101: nxt = m_pc;
            default: nxt = seq;
        endcase
        #1;
        if (check_next) chk({tag, ".pc_next"}, pc_next, nxt);
        if (m_halt) begin
            if (rs) m_halt = 1'b0;
        end else if (a) begin
            m_pc = nxt;
            if (o == 3'b011) begin
                if (m_ras.size() == DEPTH) begin
                    void'(m_ras.pop_front());
                    m_err = 1'b1;
                end
                m_ras.push_back(seq);
            end else if (o == 3'b100) begin
                if (m_ras.size() > 0) void'(m_ras.pop_back());
                else m_err = 1'b1;
            end else if (o == 3'b101) begin
                m_halt = 1'b1;
            end
        end
        push_exp(tag);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    task automatic jmp_to(input logic [31:0] target);
        logic [31:0] off;
        off = target - (m_pc + 32'd1);
        step("jmp", 1'b1, 3'b010, 2'b00, 3'b000, 16'd0, off[25:0], 1'b0, 1'b1);
    endtask

    initial begin
        // Reset dominates a committing JMP
        do_reset(2);

        // Conditional branch taken / not taken
        jmp_to(32'd10);
        step("br_taken", 1'b1, 3'b001, 2'b00, 3'b001, 16'hFFFC, 26'd0, 1'b0, 1'b1);
        jmp_to(32'd10);
        step("br_not", 1'b1, 3'b001, 2'b00, 3'b000, 16'hFFFC, 26'd0, 1'b0, 1'b1);
        step("br_nz", 1'b1, 3'b001, 2'b01, 3'b000, 16'd20, 26'd0, 1'b0, 1'b1);
        step("br_s1", 1'b1, 3'b001, 2'b11, 3'b010, 16'd3, 26'd0, 1'b0, 1'b1);
        step("br_s0", 1'b1, 3'b001, 2'b10, 3'b010, 16'd3, 26'd0, 1'b0, 1'b1);
        step("hold", 1'b0, 3'b010, 2'b00, 3'b000, 16'd0, 26'd77, 1'b0, 1'b1);
        step("op7", 1'b1, 3'b111, 2'b00, 3'b000, 16'd0, 26'd77, 1'b0, 1'b1);

        // Call then return
        jmp_to(32'd20);
        step("call", 1'b1, 3'b011, 2'b00, 3'b000, 16'd0, 26'd100, 1'b0, 1'b1);
        step("ret", 1'b1, 3'b100, 2'b00, 3'b000, 16'd0, 26'd0, 1'b0, 1'b1);

        // Overflow, LIFO drain, underflow
        for (int i = 0; i < DEPTH + 1; i++)
            step("ovf_call", 1'b1, 3'b011, 2'b00, 3'b000, 16'd0, 26'd50, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH + 1; i++)
            step("drain_ret", 1'b1, 3'b100, 2'b00, 3'b000, 16'd0, 26'd0, 1'b0, 1'b1);

        // HALT freezes everything until resume
        jmp_to(32'd40);
        step("halt", 1'b1, 3'b101, 2'b00, 3'b000, 16'd0, 26'd0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++)
            step("halted_adv", 1'b1, 3'b010, 2'b00, 3'b000, 16'd0, 26'd9, 1'b0, 1'b0);
        step("resume", 1'b1, 3'b010, 2'b00, 3'b000, 16'd0, 26'd9, 1'b1, 1'b0);
        step("after_res", 1'b1, 3'b000, 2'b00, 3'b000, 16'd0, 26'd0, 1'b0, 1'b1);
        step("run_res", 1'b0, 3'b000, 2'b00, 3'b000, 16'd0, 26'd0, 1'b1, 1'b1);

        // Address wrap, then reset while halted with a populated stack
        do_reset(1);
        jmp_to(32'hFFFF_FFFF);
        step("wrap", 1'b1, 3'b000, 2'b00, 3'b000, 16'd0, 26'd0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++)
            step("pre_call", 1'b1, 3'b011, 2'b00, 3'b000, 16'd0, 26'd4, 1'b0, 1'b1);
        step("pre_halt", 1'b1, 3'b101, 2'b00, 3'b000, 16'd0, 26'd0, 1'b0, 1'b1);
        do_reset(1);
        step("post_ret", 1'b1, 3'b100, 2'b00, 3'b000, 16'd0, 26'd0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
